ping_scheduler: RTL
===================

# ping_scheduler

Time-multiplexes up to N ultrasonic ping drivers so only one sensor transmits or listens at any time, preventing acoustic crosstalk between sensors. Each driver is held in reset except during its own slot. At the end of the slot the scheduler captures that driver's distance. After each sweep it reports the nearest echo and an obstacle flag to the vehicle control logic. It sits between the per-sensor ping drivers and the steering/motor controller.

## Interface
- N_SENSORS, 4: number of ping drivers scheduled (1..8)
- WIDTH, 16: distance and timer width
- PING_CYCLES, 16'd6010: slot length in clocks; must be ≥ one full driver transmit+measure cycle
- GUARD_CYCLES, 16'd1000: quiet gap between slots, for echo decay
- OBSTACLE_THRESH, 16'd1000: distance below which `obstacle` asserts
- clk  in  1  1 MHz system clock
- reset  in  1  asynchronous, active-high reset
- run  in  1  level; enables sweeping
- sensor_mask  in  N_SENSORS  1 = sensor included in sweep
- distance_bus  in  N_SENSORS*WIDTH  driver distances; sensor i occupies bits [i*WIDTH +: WIDTH]
- hold  out  N_SENSORS  per-driver reset; OR'd into the driver's reset
- active_index  out  3  sensor currently owning the slot
- result_valid  out  1  one-cycle pulse; a new per-sensor result is present
- result_index  out  3  sensor of the latest result
- result_distance  out  WIDTH  distance of the latest result
- sweep_done  out  1  one-cycle pulse at sweep end
- nearest_distance  out  WIDTH  minimum nonzero distance of the last sweep
- nearest_index  out  3  sensor that produced `nearest_distance`
- nearest_valid  out  1  last sweep had at least one nonzero distance
- obstacle  out  1  nearest_valid && nearest_distance < OBSTACLE_THRESH

## Operation
- States: IDLE, SLOT, CAPTURE, GUARD.
- IDLE: `hold` is all ones. On `run`=1 with a nonzero mask, the scheduler latches `sensor_mask` into `sweep_mask`, selects the lowest set index, and enters SLOT.
- SLOT: `hold[active_index]`=0 and all other `hold` bits are 1. The timer counts 0..PING_CYCLES-1, then the FSM moves to CAPTURE.
- CAPTURE: lasts one cycle with `hold` unchanged. The scheduler registers the slice of `distance_bus` for `active_index`, then enters GUARD.
- GUARD: `hold` is all ones. The timer counts GUARD_CYCLES.
- On GUARD expiry:
  - If a higher set bit exists in `sweep_mask`, the scheduler moves to that sensor and enters SLOT.
  - Otherwise the sweep ends: it publishes the nearest_* outputs and pulses `sweep_done`.
  - If `run`=1 and the live mask is nonzero, it re-latches the mask and starts a new sweep at the lowest set index. Otherwise it enters IDLE.
- A distance of 0 means no echo. Such a result is still reported through result_*, but it is excluded from the nearest computation.
- The running minimum is a strict less-than compare, so on equal distances the lowest index wins. The accumulator resets to all ones at sweep start.
- If every included sensor reports 0: `nearest_valid`=0, `nearest_distance`=all ones, `obstacle`=0.
- `run` deasserted mid-sweep: the current slot completes through GUARD and the sweep ends. Nearest outputs still publish, covering the sensors sampled so far, and the FSM enters IDLE.
- `sensor_mask` changes mid-sweep are ignored until the next sweep start.

## Timing
- Reset values:
  - `hold` = all ones
  - `active_index`, `result_index`, `nearest_index` = 0
  - `result_distance` = 0
  - `nearest_distance` = all ones
  - `result_valid`, `sweep_done`, `nearest_valid`, `obstacle` = 0
  - FSM = IDLE
- IDLE to SLOT takes 1 cycle after `run` is sampled high. `hold` is a registered output and changes on the edge that enters the new state.
- A slot occupies PING_CYCLES + 1 + GUARD_CYCLES clocks. For a full mask of k sensors, the sweep period is k × (PING_CYCLES + 1 + GUARD_CYCLES).
- `result_valid` pulses in the first GUARD cycle.
- `sweep_done` and the updated nearest_*/`obstacle` outputs appear in the same cycle, which is the first cycle after the final GUARD cycle.
- The timer is WIDTH bits and saturates; it never wraps within a state.
- Asserting reset mid-slot immediately forces `hold` to all ones. This also resets every driver.

## Structure
- Shared package `ping_pkg` holds the state enum, the default slot/guard/threshold constants and the sensor count limit. The ping driver durations are also migrated into `ping_pkg`.
- One sub-module, `ping_next_index`: combinational. Given a mask and the current index, it returns the next higher set bit, or none. It is reused for the lowest-index search by passing a current index of -1.

## Test plan
Use PING_CYCLES=20, GUARD_CYCLES=4 and OBSTACLE_THRESH=100 for simulation.
- Mask 4'b1111, `run`=1, distances {300, 50, 0, 80}:
  - four `result_valid` pulses, 25 cycles apart, with indices 0..3;
  - `sweep_done` with nearest=50, index 1, obstacle=1.
- Mask 4'b1010: only indices 1 and 3 are released. `hold[0]` and `hold[2]` are never 0, and the sweep lasts 50 cycles.
- All distances 0 → `nearest_valid`=0, nearest=16'hFFFF, obstacle=0.
- Distances {90, 90, 200, 200} → nearest_index=0 (tie goes to the lowest index).
- `run` dropped during sensor 1's SLOT: sensor 1 completes, `sweep_done` pulses with nearest covering sensors 0–1, then IDLE with `hold`=4'b1111.
- Reset asserted mid-SLOT: `hold`=4'b1111 in the same cycle with all outputs at reset values. After release, the sweep restarts at the lowest mask index.

Source files
------------

// File: rtl/ping_pkg.sv
// Shared constants for the ultrasonic ping scheduler and its ping drivers.
package ping_pkg;

  // Sensor count limit and the index width it implies.
  localparam int MAX_SENSORS = 8;
  localparam int IDX_W       = $clog2(MAX_SENSORS);

  // Ping driver durations in 1 MHz clocks: trigger burst, then the echo listen window.
  localparam int DRV_TRIGGER_CYCLES = 10;
  localparam int DRV_ECHO_CYCLES    = 6000;

  // A slot must cover a full driver transmit+measure cycle.
  localparam int DEF_PING_CYCLES     = DRV_TRIGGER_CYCLES + DRV_ECHO_CYCLES;
  localparam int DEF_GUARD_CYCLES    = 1000;
  localparam int DEF_OBSTACLE_THRESH = 1000;

  // Scheduler states.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SLOT    = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_GUARD   = 2'd3;

  typedef logic [IDX_W-1:0] idx_t;

endpackage

// File: rtl/ping_scheduler_if.sv
// Bundle between the ping scheduler, the ping drivers and the vehicle control logic.
interface ping_scheduler_if
  import ping_pkg::*;
#(
  parameter int N_SENSORS = 4,
  parameter int WIDTH     = 16
);

  logic                         run;
  logic [N_SENSORS-1:0]         sensor_mask;
  logic [N_SENSORS*WIDTH-1:0]   distance_bus;

  logic [N_SENSORS-1:0]         hold;
  idx_t                         active_index;
  logic                         result_valid;
  idx_t                         result_index;
  logic [WIDTH-1:0]             result_distance;
  logic                         sweep_done;
  logic [WIDTH-1:0]             nearest_distance;
  idx_t                         nearest_index;
  logic                         nearest_valid;
  logic                         obstacle;

  // Control side: enables sweeping, supplies mask and driver distances.
  modport master (
    output run, sensor_mask, distance_bus,
    input  hold, active_index, result_valid, result_index, result_distance,
           sweep_done, nearest_distance, nearest_index, nearest_valid, obstacle
  );

  // Scheduler side.
  modport slave (
    input  run, sensor_mask, distance_bus,
    output hold, active_index, result_valid, result_index, result_distance,
           sweep_done, nearest_distance, nearest_index, nearest_valid, obstacle
  );

endinterface

// File: rtl/ping_next_index.sv
// Finds the next set bit above a given index; pass cur = -1 to get the lowest set bit.
module ping_next_index
  import ping_pkg::*;
#(
  parameter int N_SENSORS = 4
) (
  input  logic [N_SENSORS-1:0]  mask,
  input  logic signed [IDX_W:0] cur,
  output logic                  found,
  output idx_t                  next_index
);

  // Scan downward so the lowest qualifying bit is the one left standing.
  always_comb begin
    found      = 1'b0;
    next_index = '0;
    for (int i = N_SENSORS - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(cur))) begin
        found      = 1'b1;
        next_index = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/ping_scheduler.sv
// Time-multiplexes ultrasonic ping drivers so only one transmits/listens at a time,
// captures each driver's distance and reports the nearest echo per sweep.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | all drivers held, waiting for run with a nonzero mask
// ST_SLOT    | active driver released for PING_CYCLES clocks
// ST_CAPTURE | one clock: register the active driver's distance
// ST_GUARD   | all drivers held for GUARD_CYCLES clocks (echo decay)
module ping_scheduler
  import ping_pkg::*;
#(
  parameter int N_SENSORS       = 4,
  parameter int WIDTH           = 16,
  parameter int PING_CYCLES     = DEF_PING_CYCLES,
  parameter int GUARD_CYCLES    = DEF_GUARD_CYCLES,
  parameter int OBSTACLE_THRESH = DEF_OBSTACLE_THRESH
) (
  input logic              clk,
  input logic              reset,
  ping_scheduler_if.slave  bus
);

  localparam logic [WIDTH-1:0] PING_LAST  = WIDTH'(PING_CYCLES - 1);
  localparam logic [WIDTH-1:0] GUARD_LAST = WIDTH'(GUARD_CYCLES - 1);
  localparam logic [WIDTH-1:0] THRESH     = WIDTH'(OBSTACLE_THRESH);
  localparam logic signed [IDX_W:0] CUR_NONE = '1;

  logic [1:0]           state;
  logic [WIDTH-1:0]     timer;
  logic [N_SENSORS-1:0] sweep_mask;
  idx_t                 active_index;
  logic                 stop_req;

  // Running minimum of the sweep in progress.
  logic [WIDTH-1:0]     acc_distance;
  idx_t                 acc_index;
  logic                 acc_valid;

  logic [N_SENSORS-1:0] hold_q;
  logic                 result_valid_q;
  idx_t                 result_index_q;
  logic [WIDTH-1:0]     result_distance_q;
  logic                 sweep_done_q;
  logic [WIDTH-1:0]     nearest_distance_q;
  idx_t                 nearest_index_q;
  logic                 nearest_valid_q;
  logic                 obstacle_q;

  logic                 next_found;
  idx_t                 next_index;
  logic                 low_found;
  idx_t                 low_index;
  logic [WIDTH-1:0]     cap_distance;

  // Next sensor of the latched sweep after the active one.
  ping_next_index #(.N_SENSORS(N_SENSORS)) u_next (
    .mask       (sweep_mask),
    .cur        ($signed({1'b0, active_index})),
    .found      (next_found),
    .next_index (next_index)
  );

  // Lowest sensor of the live mask, used when a sweep starts.
  ping_next_index #(.N_SENSORS(N_SENSORS)) u_low (
    .mask       (bus.sensor_mask),
    .cur        (CUR_NONE),
    .found      (low_found),
    .next_index (low_index)
  );

  assign cap_distance = bus.distance_bus[int'(active_index)*WIDTH +: WIDTH];

  function automatic logic [N_SENSORS-1:0] release_one(input idx_t idx);
    return ~(N_SENSORS'(1) << idx);
  endfunction

  // Slot sequencing, distance capture and per-sweep nearest reporting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= ST_IDLE;
      timer              <= '0;
      sweep_mask         <= '0;
      active_index       <= '0;
      stop_req           <= 1'b0;
      acc_distance       <= '1;
      acc_index          <= '0;
      acc_valid          <= 1'b0;
      hold_q             <= '1;
      result_valid_q     <= 1'b0;
      result_index_q     <= '0;
      result_distance_q  <= '0;
      sweep_done_q       <= 1'b0;
      nearest_distance_q <= '1;
      nearest_index_q    <= '0;
      nearest_valid_q    <= 1'b0;
      obstacle_q         <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      sweep_done_q   <= 1'b0;
      if (timer != '1) timer <= timer + 1'b1;
      // Once run drops, the sweep finishes after the current slot even if run returns.
      if (!bus.run) stop_req <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (bus.run && low_found) begin
            sweep_mask   <= bus.sensor_mask;
            active_index <= low_index;
            hold_q       <= release_one(low_index);
            acc_distance <= '1;
            acc_index    <= '0;
            acc_valid    <= 1'b0;
            stop_req     <= 1'b0;
            timer        <= '0;
            state        <= ST_SLOT;
          end
        end

        ST_SLOT: begin
          if (timer == PING_LAST) begin
            timer <= '0;
            state <= ST_CAPTURE;
          end
        end

        ST_CAPTURE: begin
          result_valid_q    <= 1'b1;
          result_index_q    <= active_index;
          result_distance_q <= cap_distance;
          // Zero means no echo; strict compare keeps the lowest index on ties.
          if ((cap_distance != '0) && (cap_distance < acc_distance)) begin
            acc_distance <= cap_distance;
            acc_index    <= active_index;
            acc_valid    <= 1'b1;
          end
          hold_q <= '1;
          timer  <= '0;
          state  <= ST_GUARD;
        end

        ST_GUARD: begin
          if (timer == GUARD_LAST) begin
            timer <= '0;
            if (next_found && bus.run && !stop_req) begin
              active_index <= next_index;
              hold_q       <= release_one(next_index);
              state        <= ST_SLOT;
            end else begin
              sweep_done_q       <= 1'b1;
              nearest_distance_q <= acc_distance;
              nearest_index_q    <= acc_index;
              nearest_valid_q    <= acc_valid;
              obstacle_q         <= acc_valid && (acc_distance < THRESH);
              if (bus.run && low_found) begin
                sweep_mask   <= bus.sensor_mask;
                active_index <= low_index;
                hold_q       <= release_one(low_index);
                acc_distance <= '1;
                acc_index    <= '0;
                acc_valid    <= 1'b0;
                stop_req     <= 1'b0;
                state        <= ST_SLOT;
              end else begin
                hold_q <= '1;
                state  <= ST_IDLE;
              end
            end
          end
        end

        default: begin
          hold_q <= '1;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.hold             = hold_q;
  assign bus.active_index     = active_index;
  assign bus.result_valid     = result_valid_q;
  assign bus.result_index     = result_index_q;
  assign bus.result_distance  = result_distance_q;
  assign bus.sweep_done       = sweep_done_q;
  assign bus.nearest_distance = nearest_distance_q;
  assign bus.nearest_index    = nearest_index_q;
  assign bus.nearest_valid    = nearest_valid_q;
  assign bus.obstacle         = obstacle_q;

endmodule
